arbitro_extensor: RTL and testbench

Shared immediate-extension unit with two-requester round-robin arbitration. It serializes 16-bit immediates from the decode stage (requester 0) and the branch/jump address unit (requester 1) through one extension datapath. Each immediate is widened to 32 bits by sign-extension, zero-extension or upper-half placement. Results are registered and returned with a requester tag under valid/ready backpressure.

---
 rtl/arbitro_extensor_if.sv | 30 +++
 rtl/arbitro_extensor.sv | 115 +++++++++++
 tb/tb_arbitro_extensor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/arbitro_extensor_if.sv
// Handshake bundle for arbitro_extensor: two requesters in, one tagged result out.
// slave = the extension unit, master = requesters plus result consumer.
interface arbitro_extensor_if #(
    parameter int LARGURA_IN  = 16,
    parameter int LARGURA_OUT = 32
);
    logic                   req0;
    logic                   req1;
    logic [LARGURA_IN-1:0]  imm0;
    logic [LARGURA_IN-1:0]  imm1;
    logic [1:0]             modo0;
    logic [1:0]             modo1;
    logic                   gnt0;
    logic                   gnt1;
    logic                   res_valid;
    logic                   res_ready;
    logic [LARGURA_OUT-1:0] res_dado;
    logic                   res_id;
    logic                   ocupado;

    modport slave (
        input  req0, req1, imm0, imm1, modo0, modo1, res_ready,
        output gnt0, gnt1, res_valid, res_dado, res_id, ocupado
    );

    modport master (
        output req0, req1, imm0, imm1, modo0, modo1, res_ready,
        input  gnt0, gnt1, res_valid, res_dado, res_id, ocupado
    );
endinterface

// File: rtl/arbitro_extensor.sv
// Round-robin shared immediate extender (sign/zero/upper) with registered, tagged result.
// Define ARBITRO_EXTENSOR_UPPER_EN to enable mode 2 (upper placement); otherwise mode 2 flags erro.
module arbitro_extensor #(
    parameter int LARGURA_IN  = 16,
    parameter int LARGURA_OUT = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    arbitro_extensor_if.slave bus
);
    localparam int EXT = LARGURA_OUT - LARGURA_IN;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    estado_t                estado;
    estado_t                proximo;
    logic                   ultimo;
    logic                   erro;
    logic                   livre;
    logic                   gnt0;
    logic                   gnt1;
    logic                   concedido;
    logic                   sel;
    logic [LARGURA_IN-1:0]  imm_sel;
    logic [1:0]             modo_sel;
    logic [LARGURA_OUT-1:0] estendido;
    logic                   invalido;
    logic [LARGURA_OUT-1:0] dado;
    logic                   id;

    assign livre = (estado == VAZIO) || bus.res_ready;

    // Grants are held low during reset so a waiting requester is not captured.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && livre) begin
            if (bus.req0 && bus.req1) begin
                gnt0 = ultimo;
                gnt1 = !ultimo;
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
    end

    assign concedido = gnt0 || gnt1;
    assign sel       = gnt1;
    assign imm_sel   = sel ? bus.imm1  : bus.imm0;
    assign modo_sel  = sel ? bus.modo1 : bus.modo0;

    always_comb begin
        estendido = '0;
        invalido  = 1'b0;
        case (modo_sel)
            2'd0: estendido = {{EXT{imm_sel[LARGURA_IN-1]}}, imm_sel};
            2'd1: estendido = {{EXT{1'b0}}, imm_sel};
`ifdef ARBITRO_EXTENSOR_UPPER_EN
            2'd2: estendido = {imm_sel, {EXT{1'b0}}};
`else
            2'd2: begin
                estendido = '0;
                invalido  = 1'b1;
            end
`endif
            default: begin
                estendido = '0;
                invalido  = 1'b1;
            end
        endcase
    end

    always_comb begin
        proximo = estado;
        case (estado)
            VAZIO: if (concedido) proximo = CHEIO;
            CHEIO: if (bus.res_ready && !concedido) proximo = VAZIO;
            default: proximo = VAZIO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= VAZIO;
        end else begin
            estado <= proximo;
        end
    end

    // Pointer starts at 1 so the first contested grant goes to requester 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dado   <= '0;
            id     <= 1'b0;
            ultimo <= 1'b1;
            erro   <= 1'b0;
        end else if (concedido) begin
            dado   <= estendido;
            id     <= sel;
            ultimo <= sel;
            if (invalido) erro <= 1'b1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.res_valid = (estado == CHEIO);
    assign bus.res_dado  = dado;
    assign bus.res_id    = id;
    assign bus.ocupado   = (estado == CHEIO) || bus.req0 || bus.req1;
endmodule

// File: tb/tb_arbitro_extensor.sv
// Bench for arbitro_extensor: directed scenarios plus random traffic against a cycle model.
module tb_arbitro_extensor;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    arbitro_extensor_if #(.LARGURA_IN(16), .LARGURA_OUT(32)) bus ();

    arbitro_extensor #(.LARGURA_IN(16), .LARGURA_OUT(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          m_valid;
    logic [31:0] m_dado;
    bit          m_id;
    bit          m_ultimo;
    bit          m_erro;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, esp);
        end
    endtask

    function automatic logic [31:0] estende(input logic [15:0] imm, input logic [1:0] modo);
        case (modo)
            2'd0: return (imm >= 16'h8000) ? 32'(imm) + 32'hFFFF_0000 : 32'(imm);
            2'd1: return 32'(imm);
`ifdef ARBITRO_EXTENSOR_UPPER_EN
            2'd2: return 32'(imm) * 32'd65536;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit modo_invalido(input logic [1:0] modo);
`ifdef ARBITRO_EXTENSOR_UPPER_EN
        return modo == 2'd3;
`else
        return modo >= 2'd2;
`endif
    endfunction

    task automatic modelo_reset();
        m_valid  = 1'b0;
        m_dado   = 32'h0;
        m_id     = 1'b0;
        m_ultimo = 1'b1;
        m_erro   = 1'b0;
    endtask

    // Enters and leaves at a falling edge; checks grants before the edge, results after.
    task automatic ciclo(input bit r0, input bit r1, input logic [15:0] i0, input logic [15:0] i1,
                         input logic [1:0] md0, input logic [1:0] md1, input bit rdy,
                         output bit g0, output bit g1);
        bit livre;
        bus.req0 = r0;  bus.req1 = r1;
        bus.imm0 = i0;  bus.imm1 = i1;
        bus.modo0 = md0; bus.modo1 = md1;
        bus.res_ready = rdy;
        #1;
        livre = !m_valid || rdy;
        g0 = livre && r0 && (!r1 || m_ultimo);
        g1 = livre && r1 && (!r0 || !m_ultimo);
        confere("gnt0", bus.gnt0, g0);
        confere("gnt1", bus.gnt1, g1);
        confere("ocupado", bus.ocupado, m_valid || r0 || r1);
        @(posedge clock);
        if (g0 || g1) begin
            m_valid  = 1'b1;
            m_id     = g1;
            m_ultimo = g1;
            m_dado   = g1 ? estende(i1, md1) : estende(i0, md0);
            if (modo_invalido(g1 ? md1 : md0)) m_erro = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
        confere("res_valid", bus.res_valid, m_valid);
        confere("res_id", bus.res_id, m_id);
        confere("res_dado", bus.res_dado, m_dado);
        confere("erro", dut.erro, m_erro);
    endtask

    task automatic aplica_reset(input bit r0);
        reset_n = 1'b0;
        bus.req0 = r0; bus.req1 = 1'b0;
        bus.imm0 = 16'h0; bus.imm1 = 16'h0;
        bus.modo0 = 2'd0; bus.modo1 = 2'd0;
        bus.res_ready = 1'b1;
        modelo_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        confere("rst_gnt0", bus.gnt0, 1'b0);
        confere("rst_valid", bus.res_valid, 1'b0);
        confere("rst_dado", bus.res_dado, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        bit g0, g1, p0, p1;
        logic [15:0] a0, a1;
        logic [1:0] k0, k1;

        aplica_reset(1'b1);

        // Mode checks through requester 0
        ciclo(1, 0, 16'h8001, 16'h0, 2'd0, 2'd0, 1, g0, g1);
        confere("modo0_dado", bus.res_dado, 32'hFFFF_8001);
        confere("modo0_id", bus.res_id, 1'b0);
        ciclo(1, 0, 16'h8001, 16'h0, 2'd1, 2'd0, 1, g0, g1);
        confere("modo1_dado", bus.res_dado, 32'h0000_8001);
        ciclo(1, 0, 16'h8001, 16'h0, 2'd2, 2'd0, 1, g0, g1);
`ifdef ARBITRO_EXTENSOR_UPPER_EN
        confere("modo2_dado", bus.res_dado, 32'h8001_0000);
        confere("modo2_erro", dut.erro, 1'b0);
`else
        confere("modo2_dado", bus.res_dado, 32'h0);
        confere("modo2_erro", dut.erro, 1'b1);
`endif
        ciclo(0, 0, 16'h0, 16'h0, 2'd0, 2'd0, 1, g0, g1);
        aplica_reset(1'b0);
        ciclo(0, 0, 16'h0, 16'h0, 2'd3, 2'd0, 1, g0, g1);
        ciclo(1, 0, 16'h1234, 16'h0, 2'd3, 2'd0, 1, g0, g1);
        confere("modo3_dado", bus.res_dado, 32'h0);
        confere("modo3_erro", dut.erro, 1'b1);

        // Contention: alternating grants starting with requester 0
        aplica_reset(1'b0);
        for (int unsigned k = 0; k < 4; k++) begin
            ciclo(1, 1, 16'h0010 + 16'(k), 16'hF000 + 16'(k), 2'd0, 2'd1, 1, g0, g1);
            confere("disputa_id", bus.res_id, k % 2);
            confere("disputa_valid", bus.res_valid, 1'b1);
        end

        // Backpressure: result holds, pending req0 waits
        aplica_reset(1'b0);
        ciclo(0, 1, 16'h0, 16'h7FFF, 2'd0, 2'd0, 1, g0, g1);
        for (int unsigned k = 0; k < 3; k++) begin
            ciclo(1, 0, 16'hABCD, 16'h0, 2'd0, 2'd0, 0, g0, g1);
            confere("bp_dado", bus.res_dado, 32'h0000_7FFF);
            confere("bp_valid", bus.res_valid, 1'b1);
        end
        ciclo(1, 0, 16'hABCD, 16'h0, 2'd0, 2'd0, 1, g0, g1);
        confere("bp_novo_dado", bus.res_dado, 32'hFFFF_ABCD);
        confere("bp_novo_id", bus.res_id, 1'b0);

        // Async reset while holding a result
        ciclo(0, 1, 16'h0, 16'h5555, 2'd1, 2'd0, 0, g0, g1);
        confere("hold_valid", bus.res_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1 confere("async_valid", bus.res_valid, 1'b0);
        confere("async_gnt", bus.gnt0 | bus.gnt1, 1'b0);
        modelo_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        ciclo(1, 1, 16'h0042, 16'h0043, 2'd1, 2'd1, 1, g0, g1);
        confere("pos_reset_id", bus.res_id, 1'b0);
        confere("pos_reset_dado", bus.res_dado, 32'h0000_0042);

        // Random traffic; requesters hold req and operands until granted
        aplica_reset(1'b0);
        p0 = 0; p1 = 0;
        a0 = '0; a1 = '0; k0 = '0; k1 = '0;
        for (int unsigned n = 0; n < 400; n++) begin
            if (!p0 && ($urandom % 3 != 0)) begin
                p0 = 1; a0 = 16'($urandom); k0 = 2'($urandom_range(0, 3));
            end
            if (!p1 && ($urandom % 3 != 0)) begin
                p1 = 1; a1 = 16'($urandom); k1 = 2'($urandom_range(0, 3));
            end
            ciclo(p0, p1, a0, a1, k0, k1, ($urandom % 4) != 0, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
